zero_frame_accum: RTL and testbench

Frame-level accumulator placed directly downstream of the 8-bit zero counter. Consumes one 4-bit per-byte zero count per accepted beat over a valid/ready interface. Sums counts across a frame of FRAME_LEN bytes, or fewer if the frame is cut short by `in_last`. Presents the frame total, the per-byte maximum, the byte count and status flags on a held valid/ready output.

---
 rtl/zero_frame_accum.sv | 112 +++++++++++
 tb/tb_zero_frame_accum.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/zero_frame_accum.sv
// rtl/zero_frame_accum.sv - frame accumulator of per-byte zero counts with held result handshake
module zero_frame_accum #(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 8,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_count,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [3:0]       out_max,
    output logic [CNT_W-1:0] out_nbytes,
    output logic             out_sat,
    output logic             out_err
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [ACC_W:0] TOTAL_MAX   = {1'b0, {ACC_W{1'b1}}};
    localparam logic [CNT_W:0] FRAME_LEN_W = (CNT_W + 1)'(FRAME_LEN);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [3:0]       max_q, max_d;
    logic [CNT_W-1:0] nbytes_q, nbytes_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;

    logic             accept;
    logic             over_range;
    logic [3:0]       clamped;
    logic [ACC_W:0]   raw_sum;
    logic [CNT_W:0]   nbytes_inc;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);

    assign accept     = in_valid && in_ready;
    assign over_range = (in_count > 4'd8);
    assign clamped    = over_range ? 4'd8 : in_count;
    // One extra bit keeps the carry so saturation can be detected before clipping.
    assign raw_sum    = {1'b0, total_q} + {{(ACC_W - 3){1'b0}}, clamped};
    assign nbytes_inc = {1'b0, nbytes_q} + 1'b1;

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        max_d    = max_q;
        nbytes_d = nbytes_q;
        sat_d    = sat_q;
        err_d    = err_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    total_d  = (raw_sum > TOTAL_MAX) ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
                    max_d    = (clamped > max_q) ? clamped : max_q;
                    nbytes_d = nbytes_inc[CNT_W-1:0];
                    sat_d    = sat_q || (raw_sum > TOTAL_MAX);
                    err_d    = err_q || over_range;
                    if (in_last || (nbytes_inc == FRAME_LEN_W)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Result is dropped on the handshake edge so the next frame starts clean.
                if (out_ready) begin
                    state_d  = ST_ACC;
                    total_d  = '0;
                    max_d    = '0;
                    nbytes_d = '0;
                    sat_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ACC;
            total_q  <= '0;
            max_q    <= '0;
            nbytes_q <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            max_q    <= max_d;
            nbytes_q <= nbytes_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
        end
    end

    assign out_total  = total_q;
    assign out_max    = max_q;
    assign out_nbytes = nbytes_q;
    assign out_sat    = sat_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_zero_frame_accum.sv
// tb/tb_zero_frame_accum.sv - directed self-checking bench for zero_frame_accum
module tb_zero_frame_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_count = 4'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_sat, out_err;
    logic [7:0] out_total;
    logic [3:0] out_max;
    logic [4:0] out_nbytes;

    logic       in_ready_n, out_valid_n, out_sat_n, out_err_n;
    logic [5:0] out_total_n;
    logic [3:0] out_max_n;
    logic [4:0] out_nbytes_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    zero_frame_accum dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_total(out_total), .out_max(out_max), .out_nbytes(out_nbytes),
        .out_sat(out_sat), .out_err(out_err)
    );

    zero_frame_accum #(.ACC_W(6)) dut_narrow (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_count(in_count), .in_last(in_last),
        .out_valid(out_valid_n), .out_ready(out_ready),
        .out_total(out_total_n), .out_max(out_max_n), .out_nbytes(out_nbytes_n),
        .out_sat(out_sat_n), .out_err(out_err_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [3:0] cnt, input logic last);
        in_valid = 1'b1;
        in_count = cnt;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
        check("release_total", out_total, 0);
    endtask

    initial begin
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_total", out_total, 0);
        check("rst_nbytes", out_nbytes, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) beat(4'd8, 1'b0);
        check("full_valid", out_valid, 1);
        check("full_total", out_total, 128);
        check("full_max", out_max, 8);
        check("full_nbytes", out_nbytes, 16);
        check("full_sat", out_sat, 0);
        check("full_err", out_err, 0);
        check("full_ready", in_ready, 0);
        check("narrow_total", out_total_n, 63);
        check("narrow_sat", out_sat_n, 1);
        repeat (2) @(posedge clk);
        #1;
        check("full_hold_ready", in_ready, 0);
        release_frame();

        beat(4'd1, 1'b0);
        beat(4'd2, 1'b0);
        beat(4'd3, 1'b1);
        check("short_valid", out_valid, 1);
        check("short_total", out_total, 6);
        check("short_max", out_max, 3);
        check("short_nbytes", out_nbytes, 3);
        release_frame();
        beat(4'd5, 1'b1);
        check("one_total", out_total, 5);
        check("one_nbytes", out_nbytes, 1);
        release_frame();

        for (int i = 0; i < 16; i++) beat(4'd1, 1'b0);
        check("ones_total", out_total, 16);
        in_valid = 1'b1;
        in_count = 4'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_ready", in_ready, 0);
            check("stall_total", out_total, 16);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("rel_total", out_total, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("new_total", out_total, 7);
        check("new_nbytes", out_nbytes, 1);
        beat(4'd0, 1'b1);
        check("new_end_valid", out_valid, 1);
        check("new_end_nbytes", out_nbytes, 2);
        release_frame();

        beat(4'd12, 1'b1);
        check("err_total", out_total, 8);
        check("err_max", out_max, 8);
        check("err_flag", out_err, 1);
        check("err_nbytes", out_nbytes, 1);
        release_frame();

        for (int i = 0; i < 5; i++) beat(4'd3, 1'b0);
        check("pre_rst_total", out_total, 15);
        #2 rst = 1'b1;
        #1;
        check("async_ready", in_ready, 1);
        check("async_valid", out_valid, 0);
        check("async_total", out_total, 0);
        check("async_nbytes", out_nbytes, 0);
        check("async_max", out_max, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) beat(4'd2, 1'b0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_total", out_total, 32);
        check("post_rst_nbytes", out_nbytes, 16);
        check("post_rst_max", out_max, 2);
        release_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
